sfq_dff_checker: RTL and testbench

- Clocked, synchronous-domain checker that sits directly downstream of the SFQ D flip-flop cell model.
- Consumes the cell's pulse interface: the set pulse, the reset/readout pulse, and the out pulse, each already digitised to single-cycle strobes.
- Runs a golden copy of the cell's state machine (state 0, state 1, error) and checks each out pulse against it.
- Counts good, missing and spurious outputs; flags illegal input sequences. Used in regression benches and in on-chip test harness emulation.

---
 rtl/sfq_dff_checker_pkg.sv | 18 +
 rtl/sfq_dff_checker_sat_counter.sv | 25 ++
 rtl/sfq_dff_checker.sv | 166 ++++++++++++++++
 tb/tb_sfq_dff_checker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sfq_dff_checker_pkg.sv
// Shared types for the SFQ DFF golden-model checker.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S1  = 2'd1,
        ERR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        DOUBLE_SET = 2'd1,
        SIMUL      = 2'd2
    } err_code_t;

    localparam int unsigned OUT_WIN_DEF = 4;

endpackage

// File: rtl/sfq_dff_checker_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module sat_counter
    import dff_chk_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/sfq_dff_checker.sv
// Golden SFQ DFF state machine plus out-pulse window checker.
// Optional DFF_CHK_TIMESTAMP_EN adds a cycle counter and first-error timestamp.
module sfq_dff_checker
    import dff_chk_pkg::*;
#(
    parameter int unsigned OUT_WIN = OUT_WIN_DEF,
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_p,
    input  logic          read_p,
    input  logic          out_p,
    input  logic          clr_err,
    output logic [1:0]    state,
    output logic          err_flag,
    output logic [1:0]    err_code,
    output logic [CW-1:0] ok_cnt,
    output logic [CW-1:0] miss_cnt,
    output logic [CW-1:0] spur_cnt
`ifdef DFF_CHK_TIMESTAMP_EN
    ,
    output logic [31:0]   first_err_t,
    output logic          first_err_v
`endif
);

    localparam logic [3:0] LP_WIN = 4'(OUT_WIN);

    state_t    r_state;
    err_code_t r_err_code;
    logic      r_err_flag;
    logic      r_armed;
    logic [3:0] r_timer;

    logic w_arm;
    logic w_ok;
    logic w_miss;
    logic w_spur;
    logic w_err_entry;

    // A pending window is resolved before any re-arm in the same cycle.
    assign w_arm       = (r_state == S1) && read_p && !set_p;
    assign w_ok        = r_armed && out_p;
    assign w_miss      = r_armed && !out_p && (w_arm || (r_timer == 4'd1));
    assign w_spur      = out_p && !r_armed;
    assign w_err_entry = (r_state != ERR) && set_p && (read_p || (r_state == S1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S0;
            r_err_code <= NONE;
            r_err_flag <= 1'b0;
        end else begin
            case (r_state)
                S0: begin
                    if (set_p && read_p) begin
                        r_state    <= ERR;
                        r_err_code <= SIMUL;
                        r_err_flag <= 1'b1;
                    end else if (set_p) begin
                        r_state <= S1;
                    end
                end
                S1: begin
                    if (set_p && read_p) begin
                        r_state    <= ERR;
                        r_err_code <= SIMUL;
                        r_err_flag <= 1'b1;
                    end else if (set_p) begin
                        r_state    <= ERR;
                        r_err_code <= DOUBLE_SET;
                        r_err_flag <= 1'b1;
                    end else if (read_p) begin
                        r_state <= S0;
                    end
                end
                ERR: begin
                    if (clr_err) begin
                        r_state    <= S0;
                        r_err_code <= NONE;
                        r_err_flag <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S0;
                    r_err_code <= NONE;
                    r_err_flag <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
            r_timer <= '0;
        end else if (w_arm) begin
            r_armed <= 1'b1;
            r_timer <= LP_WIN;
        end else if (r_armed) begin
            if (out_p || (r_timer == 4'd1)) begin
                r_armed <= 1'b0;
                r_timer <= '0;
            end else begin
                r_timer <= r_timer - 4'd1;
            end
        end
    end

    sat_counter #(.CW(CW)) u_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_ok),
        .count (ok_cnt)
    );

    sat_counter #(.CW(CW)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_miss),
        .count (miss_cnt)
    );

    sat_counter #(.CW(CW)) u_spur_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_spur),
        .count (spur_cnt)
    );

    assign state    = r_state;
    assign err_flag = r_err_flag;
    assign err_code = r_err_code;

`ifdef DFF_CHK_TIMESTAMP_EN
    logic [31:0] r_cyc;
    logic [31:0] r_first_t;
    logic        r_first_v;
    logic        w_first_evt;

    assign w_first_evt = w_err_entry || w_miss || w_spur;

    // Stamp is the number of edges since the reset edge, counting the event edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc     <= '0;
            r_first_t <= '0;
            r_first_v <= 1'b0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_first_evt && !r_first_v) begin
                r_first_t <= r_cyc + 32'd1;
                r_first_v <= 1'b1;
            end
        end
    end

    assign first_err_t = r_first_t;
    assign first_err_v = r_first_v;
`else
    logic w_unused;
    assign w_unused = w_err_entry;
`endif

endmodule

// File: tb/tb_sfq_dff_checker.sv
// Self-checking bench: directed vector table, saturation sequence, randomized model check.
module tb_sfq_dff_checker;

    localparam int unsigned WIN = 4;

    logic       clk;
    logic       rst;
    logic       set_p;
    logic       read_p;
    logic       out_p;
    logic       clr_err;
    logic [1:0] state;
    logic       err_flag;
    logic [1:0] err_code;
    logic [7:0] ok_cnt;
    logic [7:0] miss_cnt;
    logic [7:0] spur_cnt;
    logic [1:0] state2;
    logic       err_flag2;
    logic [1:0] err_code2;
    logic [1:0] ok_cnt2;
    logic [1:0] miss_cnt2;
    logic [1:0] spur_cnt2;
`ifdef DFF_CHK_TIMESTAMP_EN
    logic [31:0] ts_t;
    logic        ts_v;
    logic [31:0] ts_t2;
    logic        ts_v2;
`endif

    int n_vec = 0;
    int n_mis = 0;

    sfq_dff_checker #(.OUT_WIN(WIN), .CW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_p    (set_p),
        .read_p   (read_p),
        .out_p    (out_p),
        .clr_err  (clr_err),
        .state    (state),
        .err_flag (err_flag),
        .err_code (err_code),
        .ok_cnt   (ok_cnt),
        .miss_cnt (miss_cnt),
        .spur_cnt (spur_cnt)
`ifdef DFF_CHK_TIMESTAMP_EN
        ,
        .first_err_t (ts_t),
        .first_err_v (ts_v)
`endif
    );

    sfq_dff_checker #(.OUT_WIN(WIN), .CW(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .set_p    (set_p),
        .read_p   (read_p),
        .out_p    (out_p),
        .clr_err  (clr_err),
        .state    (state2),
        .err_flag (err_flag2),
        .err_code (err_code2),
        .ok_cnt   (ok_cnt2),
        .miss_cnt (miss_cnt2),
        .spur_cnt (spur_cnt2)
`ifdef DFF_CHK_TIMESTAMP_EN
        ,
        .first_err_t (ts_t2),
        .first_err_v (ts_v2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic s, r, o, c, rs;
        int   st, code, ok, miss, spur;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic s, r, o, c, rs, input int st, code, ok, miss, spur);
        vec_t v;
        v.s = s; v.r = r; v.o = o; v.c = c; v.rs = rs;
        v.st = st; v.code = code; v.ok = ok; v.miss = miss; v.spur = spur;
        tbl.push_back(v);
    endfunction

    function automatic int cap(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic step(input logic s, r, o, c, rs);
        @(negedge clk);
        set_p = s; read_p = r; out_p = o; clr_err = c; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int st, code, ok, miss, spur);
        logic bad;
        n_vec++;
        bad = (int'(state) != st) || (err_flag !== (st == 2)) || (int'(err_code) != code)
            || (int'(ok_cnt) != cap(ok, 255)) || (int'(miss_cnt) != cap(miss, 255))
            || (int'(spur_cnt) != cap(spur, 255)) || (int'(state2) != st)
            || (int'(ok_cnt2) != cap(ok, 3)) || (int'(miss_cnt2) != cap(miss, 3))
            || (int'(spur_cnt2) != cap(spur, 3));
        if (bad) begin
            n_mis++;
            $display("FAIL %s: got st=%0d flag=%0b code=%0d ok=%0d miss=%0d spur=%0d | cw2 st=%0d ok=%0d miss=%0d spur=%0d ; want st=%0d code=%0d ok=%0d miss=%0d spur=%0d",
                     tag, state, err_flag, err_code, ok_cnt, miss_cnt, spur_cnt,
                     state2, ok_cnt2, miss_cnt2, spur_cnt2, st, code, ok, miss, spur);
        end
    endtask

    // Reference model: absolute-time window bookkeeping.
    int  m_st, m_code, m_ok, m_miss, m_spur, m_cyc, m_rd_t;
    bit  m_armed;

    task automatic mdl_step(input logic s, r, o, c, rs);
        bit arm;
        m_cyc++;
        if (rs) begin
            m_st = 0; m_code = 0; m_ok = 0; m_miss = 0; m_spur = 0; m_armed = 0;
            return;
        end
        arm = (m_st == 1) && r && !s;
        if (m_armed) begin
            if (o) begin
                m_ok++; m_armed = 0;
            end else if (arm || (m_cyc == m_rd_t + int'(WIN))) begin
                m_miss++; m_armed = 0;
            end
        end else if (o) begin
            m_spur++;
        end
        if (arm) begin
            m_armed = 1; m_rd_t = m_cyc;
        end
        if (m_st == 2) begin
            if (c) begin m_st = 0; m_code = 0; end
        end else if (s && r) begin
            m_st = 2; m_code = 2;
        end else if (s) begin
            if (m_st == 1) begin m_st = 2; m_code = 1; end
            else m_st = 1;
        end else if (r) begin
            m_st = 0;
        end
    endtask

    initial begin
        set_p = 0; read_p = 0; out_p = 0; clr_err = 0; rst = 0;

        // nominal
        add(0,0,0,0,1, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0);
        add(0,0,0,0,0, 1,0,0,0,0); add(0,0,0,0,0, 1,0,0,0,0); add(0,1,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0); add(0,0,1,0,0, 0,0,1,0,0); add(0,0,0,0,0, 0,0,1,0,0);
        // double set, ignored read, clr, then out proves no window
        add(0,0,0,0,1, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0);
        add(0,0,0,0,0, 1,0,0,0,0); add(1,0,0,0,0, 2,1,0,0,0); add(0,0,0,0,0, 2,1,0,0,0);
        add(0,1,0,0,0, 2,1,0,0,0); add(0,0,0,0,0, 2,1,0,0,0); add(0,0,0,1,0, 0,0,0,0,0);
        add(0,0,1,0,0, 0,0,0,0,1);
        // missing output, then late out is spurious
        add(0,0,0,0,1, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0); add(0,0,0,0,0, 1,0,0,0,0);
        add(0,1,0,0,0, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,1,0); add(0,0,1,0,0, 0,0,0,1,1);
        // out on last legal cycle
        add(0,0,0,0,1, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0); add(0,1,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0);
        add(0,0,1,0,0, 0,0,1,0,0); add(0,0,0,0,0, 0,0,1,0,0);
        // empty read then spurious out
        add(0,0,0,0,1, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0);
        add(0,1,0,0,0, 0,0,0,0,0); add(0,0,1,0,0, 0,0,0,0,1); add(0,0,0,0,0, 0,0,0,0,1);
        // simultaneous set+read, reset, clr in S0 no effect
        add(0,0,0,0,1, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0);
        add(1,1,0,0,0, 2,2,0,0,0); add(0,0,0,0,0, 2,2,0,0,0); add(0,0,1,0,0, 2,2,0,0,1);
        add(0,0,0,0,1, 0,0,0,0,0); add(0,0,0,1,0, 0,0,0,0,0);
        // re-arm without out: old window missed
        add(0,0,0,0,1, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0); add(0,1,0,0,0, 0,0,0,0,0);
        add(1,0,0,0,0, 1,0,0,0,0); add(0,1,0,0,0, 0,0,0,1,0); add(0,0,1,0,0, 0,0,1,1,0);
        add(0,0,0,0,0, 0,0,1,1,0);
        // re-arm with out: old window satisfied, new window later missed
        add(0,0,0,0,1, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0); add(0,1,0,0,0, 0,0,0,0,0);
        add(1,0,0,0,0, 1,0,0,0,0); add(0,1,1,0,0, 0,0,1,0,0); add(0,0,0,0,0, 0,0,1,0,0);
        add(0,0,0,0,0, 0,0,1,0,0); add(0,0,0,0,0, 0,0,1,0,0); add(0,0,0,0,0, 0,0,1,1,0);
        // out in arming cycle is spurious
        add(0,0,0,0,1, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0); add(0,1,1,0,0, 0,0,0,0,1);
        add(0,0,0,0,0, 0,0,0,0,1); add(0,0,0,0,0, 0,0,0,0,1); add(0,0,0,0,0, 0,0,0,0,1);
        add(0,0,0,0,0, 0,0,0,1,1);
        // window checking continues in ERR
        add(0,0,0,0,1, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0); add(0,1,0,0,0, 0,0,0,0,0);
        add(1,0,0,0,0, 1,0,0,0,0); add(1,0,0,0,0, 2,1,0,0,0); add(0,0,1,0,0, 2,1,1,0,0);
        // reset mid-window, clr in S1 no effect
        add(0,0,0,0,1, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0); add(0,1,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,1, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0); add(0,0,0,0,0, 0,0,0,0,0); add(1,0,0,0,0, 1,0,0,0,0);
        add(0,0,0,1,0, 1,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].r, tbl[i].o, tbl[i].c, tbl[i].rs);
            chk($sformatf("table[%0d]", i), tbl[i].st, tbl[i].code, tbl[i].ok, tbl[i].miss, tbl[i].spur);
        end

        // saturation: five nominal cycles, CW=2 instance holds 3
        step(0,0,0,0,1);
        for (int k = 1; k <= 5; k++) begin
            step(1,0,0,0,0);
            step(0,1,0,0,0);
            step(0,0,1,0,0);
            chk($sformatf("sat[%0d]", k), 0, 0, k, 0, 0);
        end

`ifdef DFF_CHK_TIMESTAMP_EN
        step(0,0,0,0,1);
        n_vec++;
        if (ts_v !== 1'b0) begin
            n_mis++;
            $display("FAIL ts_reset: got v=%0b want v=0", ts_v);
        end
        for (int k = 1; k <= 20; k++) step((k == 18) || (k == 20), 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,0,0,1,0);
        n_vec++;
        if (ts_v !== 1'b1 || ts_t !== 32'd20 || ts_v2 !== 1'b1 || ts_t2 !== 32'd20) begin
            n_mis++;
            $display("FAIL ts_double_set: got v=%0b t=%0d want v=1 t=20", ts_v, ts_t);
        end
`endif

        // randomized run against the model
        m_cyc = 0;
        step(0,0,0,0,1);
        mdl_step(0,0,0,0,1);
        chk("rand_reset", m_st, m_code, m_ok, m_miss, m_spur);
        for (int n = 0; n < 3000; n++) begin
            logic s, r, o, c, rs;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) == 0);
            o  = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(s, r, o, c, rs);
            mdl_step(s, r, o, c, rs);
            chk($sformatf("rand[%0d]", n), m_st, m_code, m_ok, m_miss, m_spur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
